// File: rtl/alu_seq_muldiv_if.sv
// Decoder <-> EX-stage ALU bundle: op/operand handshake, result/flags, HI/LO and busy.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] opx;
  logic [WIDTH-1:0] opy;
  logic             abort;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, op, opx, opy, abort,
    input  in_ready, out_valid, result, zero, neg, ovf, busy, hi, lo
  );

  modport slave (
    input  in_valid, op, opx, opy, abort,
    output in_ready, out_valid, result, zero, neg, ovf, busy, hi, lo
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with iterative radix-2 mul/div and HI/LO registers (MIPS-style).
// Optional signed-overflow flag for add/sub is built when ALU_OVERFLOW_EN is defined.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic             clk,
  input logic             rst,
  alu_seq_muldiv_if.slave bus
);
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, m_reg, x_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg, yzero_reg;
  logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
  logic             out_valid_reg, zero_reg, neg_reg;

  logic             accept, is_muldiv, is_signed, sx, sy;
  logic             single_done, fix_done;
  logic [WIDTH-1:0] mag_x, mag_y;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum_xy, dif_xy, alu_res;

  assign accept      = bus.in_valid && (state_reg == IDLE);
  assign is_muldiv   = (bus.op[4:2] == 3'b100);
  assign is_signed   = ~bus.op[0];
  assign sx          = is_signed & bus.opx[WIDTH-1];
  assign sy          = is_signed & bus.opy[WIDTH-1];
  assign mag_x       = sx ? -bus.opx : bus.opx;
  assign mag_y       = sy ? -bus.opy : bus.opy;
  assign single_done = accept && !is_muldiv;
  assign fix_done    = (state_reg == FIX) && !bus.abort;

  assign shamt  = bus.opy[SHW-1:0];
  assign sum_xy = bus.opx + bus.opy;
  assign dif_xy = bus.opx - bus.opy;

  always_comb begin
    alu_res = '0;
    case (bus.op)
      5'd0, 5'd13: alu_res = sum_xy;
      5'd1:        alu_res = bus.opx & bus.opy;
      5'd2:        alu_res = bus.opx ^ bus.opy;
      5'd3:        alu_res = bus.opx | bus.opy;
      5'd4:        alu_res = ~(bus.opx | bus.opy);
      5'd5, 5'd14: alu_res = dif_xy;
      5'd6:        alu_res = {{(WIDTH-1){1'b0}}, (bus.opx < bus.opy)};
      5'd7:        alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.opx) < $signed(bus.opy))};
      5'd8:        alu_res = bus.opx >> shamt;
      5'd9:        alu_res = $signed(bus.opx) >>> shamt;
      5'd10:       alu_res = bus.opx << shamt;
      5'd11:       alu_res = bus.opx;
      5'd12:       alu_res = bus.opy;
      5'd20:       alu_res = hi_reg;
      5'd21:       alu_res = lo_reg;
      5'd22, 5'd23: alu_res = bus.opx;
      default:     alu_res = '0;
    endcase
  end

  // One radix-2 step: multiply adds multiplicand then shifts {acc_hi,acc_lo} right;
  // restoring divide shifts the next dividend bit into the remainder and trial-subtracts.
  logic [WIDTH:0] mul_sum, div_trial;
  assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});
  assign div_trial = {acc_hi_reg, acc_lo_reg[WIDTH-1]} - {1'b0, m_reg};

  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  assign prod     = {acc_hi_reg, acc_lo_reg};
  assign prod_neg = -prod;

  always_comb begin
    fix_hi = acc_hi_reg;
    fix_lo = acc_lo_reg;
    if (!is_div_reg) begin
      {fix_hi, fix_lo} = neg_q_reg ? prod_neg : prod;
    end else if (yzero_reg) begin
      fix_lo = '1;
      fix_hi = x_reg;
    end else begin
      fix_lo = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
      fix_hi = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_muldiv) state_next = RUN;
      RUN:     if (bus.abort) state_next = IDLE;
               else if (cnt_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_reg == IDLE);
    bus.busy     = (state_reg != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      m_reg         <= '0;
      x_reg         <= '0;
      is_div_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      yzero_reg     <= 1'b0;
      result_reg    <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      out_valid_reg <= 1'b0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (accept && is_muldiv) begin
        cnt_reg    <= CW'(WIDTH);
        acc_hi_reg <= '0;
        acc_lo_reg <= bus.op[1] ? mag_x : mag_y;
        m_reg      <= bus.op[1] ? mag_y : mag_x;
        x_reg      <= bus.opx;
        is_div_reg <= bus.op[1];
        neg_q_reg  <= sx ^ sy;
        neg_r_reg  <= sx;
        yzero_reg  <= (bus.opy == '0);
      end
      if (single_done) begin
        result_reg    <= alu_res;
        zero_reg      <= (alu_res == '0);
        neg_reg       <= alu_res[WIDTH-1];
        out_valid_reg <= 1'b1;
        if (bus.op == 5'd22) hi_reg <= bus.opx;
        if (bus.op == 5'd23) lo_reg <= bus.opx;
      end
      if (state_reg == RUN && !bus.abort) begin
        cnt_reg <= cnt_reg - CW'(1);
        if (!is_div_reg) begin
          acc_hi_reg <= mul_sum[WIDTH:1];
          acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
          acc_hi_reg <= div_trial[WIDTH-1:0];
          acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_reg <= {acc_hi_reg[WIDTH-2:0], acc_lo_reg[WIDTH-1]};
          acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
        end
      end
      if (fix_done) begin
        hi_reg        <= fix_hi;
        lo_reg        <= fix_lo;
        result_reg    <= fix_lo;
        zero_reg      <= (fix_lo == '0);
        neg_reg       <= fix_lo[WIDTH-1];
        out_valid_reg <= 1'b1;
      end
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_calc, ovf_reg;
  // Subtract overflows when operand signs differ (X vs ~Y match) and the sign flips.
  always_comb begin
    ovf_calc = 1'b0;
    if (bus.op == 5'd13)
      ovf_calc = (bus.opx[WIDTH-1] == bus.opy[WIDTH-1]) && (sum_xy[WIDTH-1] != bus.opx[WIDTH-1]);
    else if (bus.op == 5'd14)
      ovf_calc = (bus.opx[WIDTH-1] != bus.opy[WIDTH-1]) && (dif_xy[WIDTH-1] != bus.opx[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf_reg <= 1'b0;
    else if (single_done) ovf_reg <= ovf_calc;
    else if (fix_done)    ovf_reg <= 1'b0;
  end

  assign bus.ovf = ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.neg       = neg_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
endmodule
